seg_scan_capture: RTL
=====================

# seg_scan_capture

Sequential inverse of the BCD-to-seven-segment path. It samples the multiplexed display bus (active-low segment lines plus active-low anode strobes) and waits for each digit slot to be stable. It then decodes the segment pattern back to a 4-bit code and holds one code per digit position. It sits next to the display driver as a loop-back monitor, so a bench or on-chip logic can read back what the display is actually showing.

## Interface
- DIGITS, 8: number of multiplexed digit positions (anode width), 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required before a commit, minimum 2.

- clk100_i  input  1  system clock, all logic on rising edge.
- rstn_i  input  1  reset, asynchronous, active-low.
- hex_i  input  7  segment lines, active-low, bit 6 = a … bit 0 = g.
- an_i  input  DIGITS  anode strobes, active-low, one-hot-low expected.
- digits_o  output  4*DIGITS  captured code per position; position n at [4n+3:4n].
- valid_o  output  DIGITS  bit n set once position n has committed since reset.
- err_o  output  DIGITS  bit n set when the last commit at position n was an illegal pattern.
- upd_o  output  1  one-cycle pulse on every commit.
- frame_o  output  1  one-cycle pulse when every position has committed since the previous frame pulse.

## Operation
- Input register: s_q <= {an_i, hex_i} every cycle.
- Stability counter cnt, 0..STABLE_CYCLES-1, saturating:
  - {an_i,hex_i} == s_q: cnt increments.
  - Otherwise cnt <= 0.
  - an_i not exactly one low bit (all high, or ≥2 low): cnt forced to 0, state -> WAIT.
- FSM states:
  - WAIT: cnt counting.
  - WAIT -> DONE: on the edge where cnt == STABLE_CYCLES-1 and the input still equals s_q. The commit happens on this edge.
  - DONE: holds, no further commits.
  - DONE -> WAIT: on any input change or non-one-hot anode.
  - Consequence: exactly one commit per stable dwell. A repeated dwell with the same value after a change commits again.
- Commit to position n (index of the low bit of s_q's anode field):
  - digits_o[n] <= decode(hex).
  - valid_o[n] <= 1.
  - err_o[n] <= illegal.
  - seen[n] <= 1.
  - upd_o <= 1 for one cycle.
- Decode (active-low a..g):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
  - 1111111 (blank) -> 4'hF, not an error.
  - Any other pattern -> 4'hE, illegal = 1.
- Frame: if the commit makes seen all ones (including the position just committed), frame_o pulses in the same cycle as upd_o and seen clears to 0 entirely.
- Reset values (asynchronous, immediate, also mid-dwell):
  - digits_o all 4'hF.
  - valid_o, err_o, upd_o, frame_o, seen, cnt, s_q all 0.
  - State WAIT.

## Timing
- Input change applied before edge 1 and then held: s_q updates at edge 1 (cnt=0). cnt reaches k at edge k+1. Commit at edge STABLE_CYCLES+1; with the default of 4 that is edge 5.
- digits_o, valid_o, err_o and upd_o change on the commit edge. upd_o returns to 0 on the next edge.
- A dwell shorter than STABLE_CYCLES+1 edges never commits; glitches are filtered.
- A change on the same edge as would-be commit: no commit. The equality check uses the current input.
- All outputs are registered; there are no combinational input-to-output paths.
- Throughput: at most one commit per STABLE_CYCLES+1 cycles.

## Test plan
- Reset: drive rstn_i=0 with random inputs. Required: digits_o=32'hFFFFFFFF, valid_o=0, err_o=0, upd_o=0, frame_o=0. Release reset and keep an_i=8'hFF for 20 cycles. Required: no upd_o.
- Single commit: an_i=8'hFE, hex_i=7'b0000110, held 10 cycles. Required: upd_o high only on edge 5, digits_o[3:0]=3, valid_o=8'h01, err_o=0. Exactly one pulse.
- Glitch and illegal pattern:
  - Hold an_i=8'hFB for 3 cycles, then change hex_i. Required: no commit.
  - Then hold hex_i=7'b1010101 for 6 cycles. Required: digits_o[11:8]=4'hE, err_o[2]=1.
  - Then hold hex_i=7'b1111111. Required: digits_o[11:8]=4'hF, err_o[2]=0.
- Full frame: scan positions 0..7 with digits 7,6,…,0, 6 cycles each. Required: eight upd_o pulses, frame_o coincident with the eighth, digits_o=32'h01234567.
- Second frame: rescan positions 0..7. Required: frame_o again on the eighth commit only.
- Bad anodes and reset mid-dwell:
  - an_i=8'hFC for 10 cycles. Required: no commit.
  - Assert rstn_i at cycle 3 of a valid dwell. Required: immediate reset values, and a fresh commit 5 edges after release.

Source files
------------

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if
// Multiplexed display bus as seen by a loop-back monitor, plus the monitor's
// read-back results.
//   hex_i    : active-low segment lines, bit 6 = a ... bit 0 = g
//   an_i     : active-low anode strobes, one low bit per active digit slot
//   digits_o : captured 4-bit code per position, position n at [4n+3:4n]
//   valid_o  : position has committed at least once since reset
//   err_o    : last commit at the position was an illegal segment pattern
//   upd_o    : one-cycle pulse per commit
//   frame_o  : one-cycle pulse when every position has committed
// master : display side / bench (drives the bus, reads results)
// slave  : capture block
interface seg_scan_capture_if #(
  parameter int DIGITS = 8
);
  logic [6:0]          hex_i;
  logic [DIGITS-1:0]   an_i;
  logic [4*DIGITS-1:0] digits_o;
  logic [DIGITS-1:0]   valid_o;
  logic [DIGITS-1:0]   err_o;
  logic                upd_o;
  logic                frame_o;

  modport master (
    output hex_i, an_i,
    input  digits_o, valid_o, err_o, upd_o, frame_o
  );

  modport slave (
    input  hex_i, an_i,
    output digits_o, valid_o, err_o, upd_o, frame_o
  );
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture
// Samples a multiplexed seven-segment bus, waits until a digit slot has been
// stable for STABLE_CYCLES identical samples, decodes the segment pattern back
// to a 4-bit code and stores it per digit position.
//   clk100_i : system clock, rising edge
//   rstn_i   : asynchronous active-low reset
//   bus      : seg_scan_capture_if.slave (hex_i/an_i in, results out)
module seg_scan_capture #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk100_i,
  input  logic                rstn_i,
  seg_scan_capture_if.slave   bus
);
  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {ST_WAIT, ST_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_s_q;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_valid, r_err, r_seen;
  logic                r_upd, r_frame;

  logic [SW-1:0]       w_in;
  logic [DIGITS-1:0]   w_anl, w_sel;
  logic                w_same, w_onehot, w_commit, w_frame, w_illegal;
  logic [3:0]          w_code;

  // Returns {illegal, code}; blank is a legal 4'hF.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  always_comb begin
    w_in     = {bus.an_i, bus.hex_i};
    w_anl    = ~bus.an_i;
    // Exactly one strobe low: non-zero and a power of two.
    w_onehot = (w_anl != '0) && ((w_anl & (w_anl - DIGITS'(1))) == '0);
    w_same   = (w_in == r_s_q);
    // At a commit the live input equals s_q, so the registered copy is used.
    w_sel    = ~r_s_q[SW-1:7];
    {w_illegal, w_code} = decode(r_s_q[6:0]);
  end

  // Next state / counter: the equality test uses the current input, so a
  // change on the would-be commit edge suppresses the commit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_commit    = 1'b0;
    if (!w_onehot) begin
      w_state_nxt = ST_WAIT;
    end else if (w_same) begin
      w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
      if (r_state == ST_WAIT && r_cnt == CNT_MAX) begin
        w_commit    = 1'b1;
        w_state_nxt = ST_DONE;
      end
    end else begin
      w_state_nxt = ST_WAIT;
    end
  end

  assign w_frame = w_commit && ((r_seen | w_sel) == '1);

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= ST_WAIT;
      r_s_q    <= '0;
      r_cnt    <= '0;
      r_digits <= '1;
      r_valid  <= '0;
      r_err    <= '0;
      r_seen   <= '0;
      r_upd    <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_q   <= w_in;
      r_cnt   <= w_cnt_nxt;
      r_upd   <= w_commit;
      r_frame <= w_frame;
      if (w_commit) begin
        for (int n = 0; n < DIGITS; n++) begin
          if (w_sel[n]) begin
            r_digits[4*n +: 4] <= w_code;
            r_valid[n]         <= 1'b1;
            r_err[n]           <= w_illegal;
          end
        end
        // Frame completion restarts the seen set from empty.
        r_seen <= w_frame ? '0 : (r_seen | w_sel);
      end
    end
  end

  assign bus.digits_o = r_digits;
  assign bus.valid_o  = r_valid;
  assign bus.err_o    = r_err;
  assign bus.upd_o    = r_upd;
  assign bus.frame_o  = r_frame;
endmodule
